scr1_tb_ahb_stall_inj: RTL and testbench
========================================

Name: scr1_tb_ahb_stall_inj

Overview:
- Testbench-side AHB-Lite wait-state injector, one instance per port (imem and dmem).
- Sits between the core's AHB master port and the testbench AHB memory model.
- Captures each master address phase and holds the master in its data phase for a programmable or pseudo-random number of wait cycles.
- Then replays the transfer to the memory and returns its response unchanged.
- Purpose: stress the core's AHB bridges under variable latency.

Parameters:
- STALL_W, 4, width of the stall count; maximum injected wait cycles = 2^STALL_W-1.
- LFSR_SEED, 16'hACE1, reset value of the random-stall LFSR; must be non-zero.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall_mode  in  2  0 = no injection, 1 = fixed, 2 = random, 3 = reserved (treated as 0)
- stall_val  in  STALL_W  fixed count in mode 1; bit mask applied to the LFSR in mode 2
- m_htrans  in  2  master transfer type
- m_haddr  in  32  master address
- m_hwrite  in  1  master write
- m_hsize  in  3  master size
- m_hwdata  in  32  master write data
- m_hready  out  1  ready to master
- m_hrdata  out  32  read data to master
- m_hresp  out  1  response to master (0 = OKAY, 1 = ERROR)
- s_htrans  out  2  transfer type to memory
- s_haddr  out  32  address to memory
- s_hwrite  out  1  write to memory
- s_hsize  out  3  size to memory
- s_hwdata  out  32  write data to memory
- s_hready  in  1  memory ready
- s_hrdata  in  32  memory read data
- s_hresp  in  1  memory response
- txn_cnt  out  32  completed transfers
- stall_cnt  out  32  total injected wait cycles

Behaviour:
- Reset values (async, rst_n=0), all taking effect immediately:
  - state = IDLE; m_hready=1, m_hresp=0, m_hrdata=0
  - s_htrans=2'b00, s_haddr=0, s_hwrite=0, s_hsize=0, s_hwdata=0
  - txn_cnt=0, stall_cnt=0; LFSR=LFSR_SEED
- Address capture: when m_hready=1 and m_htrans is NONSEQ(10) or SEQ(11), register haddr/hwrite/hsize and load the wait counter:
  - mode 1: stall_val
  - mode 2: lfsr[STALL_W-1:0] & stall_val
  - mode 0/3: 0
- m_htrans IDLE(00) or BUSY(01) is never captured.
- stall_mode and stall_val are sampled only at capture; changes mid-transfer have no effect on that transfer.
- FSM:
  - IDLE: m_hready=1. Capture -> WAIT if count>0, else -> ISSUE.
  - WAIT: m_hready=0. Counter decrements each cycle; stall_cnt increments each cycle; count reaches 0 -> ISSUE.
  - ISSUE (exactly 1 cycle): s_htrans=NONSEQ with the captured control. m_hready=0. -> DATA.
  - DATA: s_htrans=IDLE, s_hwdata=m_hwdata, m_hready=s_hready, m_hrdata=s_hrdata, m_hresp=s_hresp.
    - On s_hready=1: txn_cnt+1.
    - If the master presents a new NONSEQ/SEQ in that same cycle -> capture -> WAIT/ISSUE (back-to-back).
    - Otherwise -> IDLE.
- ISSUE is only ever entered after the memory completed its previous data phase, so the memory always accepts the address in ISSUE. The block does not sample s_hready in ISSUE.
- Outside DATA, s_hwdata holds its last value and m_hrdata=0, m_hresp=0.
- Latency:
  - Stall 0: address at cycle T, s address phase T+1, earliest master completion T+2 (one extra cycle vs. direct connection).
  - Stall N: earliest completion T+2+N.
  - No address pipelining across the block.
- ERROR: the two-cycle memory ERROR response (hready=0/hresp=1, then hready=1/hresp=1) is passed through cycle-exactly in DATA. txn_cnt counts the erroring transfer once.
- LFSR: 16-bit Galois, taps 0xB400, advances every cycle regardless of state. lfsr==0 is impossible because LFSR_SEED is non-zero.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.
- Reset mid-transfer: the transfer is abandoned and the FSM returns to IDLE. The memory model shares rst_n, so no pending memory transfer survives.
- Mode 0 overall behaviour: the master sees exactly one extra wait cycle per transfer.

Test Plan:
- Reset: rst_n=0 mid-WAIT with stall_val=5 -> same instant m_hready=1, s_htrans=00, both counters 0, FSM IDLE after release.
- Mode 0 read:
  - Stimulus: NONSEQ read at 0x200, memory zero-wait with hrdata=0x00000013.
  - Response: s_htrans=10 at T+1; m_hready=1, m_hrdata=0x00000013 at T+2; txn_cnt=1, stall_cnt=0.
- Mode 1, stall_val=3, write 0xDEADBEEF to 0x1000:
  - m_hready low T+1..T+4, s address at T+4, completion at T+5.
  - Memory word 0x1000=0xDEADBEEF; stall_cnt=3.
- Back-to-back: 4 SEQ reads 0x200..0x20C, mode 1 stall 2 -> each completes 4 cycles after its address; txn_cnt=4, stall_cnt=8.
- ERROR: memory returns ERROR for address 0x0 -> m_hready/m_hresp = 0/1 then 1/1 on consecutive cycles; txn_cnt=1.
- Mode 2, stall_val=4'hF, 1000 random-address reads vs. a reference memory:
  - All data matches.
  - Every per-transfer stall lies in 0..15; both 0 and 15 are observed.
  - stall_cnt equals the sum of per-transfer stalls.

Source files
------------

// File: rtl/scr1_tb_ahb_stall_inj.sv
// AHB-Lite wait-state injector placed between a master port and a memory model.
// Each address phase is held for a fixed or LFSR-derived number of wait cycles, then replayed.
module scr1_tb_ahb_stall_inj #(
  parameter int unsigned STALL_W   = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         stall_mode,
  input  logic [STALL_W-1:0] stall_val,
  input  logic [1:0]         m_htrans,
  input  logic [31:0]        m_haddr,
  input  logic               m_hwrite,
  input  logic [2:0]         m_hsize,
  input  logic [31:0]        m_hwdata,
  output logic               m_hready,
  output logic [31:0]        m_hrdata,
  output logic               m_hresp,
  output logic [1:0]         s_htrans,
  output logic [31:0]        s_haddr,
  output logic               s_hwrite,
  output logic [2:0]         s_hsize,
  output logic [31:0]        s_hwdata,
  input  logic               s_hready,
  input  logic [31:0]        s_hrdata,
  input  logic               s_hresp,
  output logic [31:0]        txn_cnt,
  output logic [31:0]        stall_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StIssue, StData} state_e;

  state_e             state;
  logic [STALL_W-1:0] wait_cnt;
  logic [15:0]        lfsr;
  logic [31:0]        addr_q;
  logic               write_q;
  logic [2:0]         size_q;
  logic [31:0]        hwdata_q;
  logic               capture;
  logic [STALL_W-1:0] load_cnt;

  assign s_haddr  = addr_q;
  assign s_hwrite = write_q;
  assign s_hsize  = size_q;

  // Only NONSEQ/SEQ address phases accepted while the master sees hready high are captured.
  assign capture = m_hready && (m_htrans == 2'b10 || m_htrans == 2'b11);

  always_comb begin
    load_cnt = '0;
    case (stall_mode)
      2'd1:    load_cnt = stall_val;
      2'd2:    load_cnt = lfsr[STALL_W-1:0] & stall_val;
      default: load_cnt = '0;
    endcase
  end

  always_comb begin
    m_hready = 1'b1;
    m_hrdata = '0;
    m_hresp  = 1'b0;
    s_htrans = 2'b00;
    s_hwdata = hwdata_q;
    case (state)
      StIdle:  m_hready = 1'b1;
      StWait:  m_hready = 1'b0;
      StIssue: begin
        m_hready = 1'b0;
        s_htrans = 2'b10;
      end
      StData:  begin
        m_hready = s_hready;
        m_hrdata = s_hrdata;
        m_hresp  = s_hresp;
        s_hwdata = m_hwdata;
      end
      default: m_hready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      wait_cnt  <= '0;
      lfsr      <= LFSR_SEED;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      hwdata_q  <= '0;
      txn_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (capture) begin
        addr_q   <= m_haddr;
        write_q  <= m_hwrite;
        size_q   <= m_hsize;
        wait_cnt <= load_cnt;
      end
      case (state)
        StIdle: begin
          if (capture) state <= (load_cnt != '0) ? StWait : StIssue;
        end
        StWait: begin
          wait_cnt  <= wait_cnt - STALL_W'(1);
          stall_cnt <= stall_cnt + 32'd1;
          if (wait_cnt == STALL_W'(1)) state <= StIssue;
        end
        StIssue: state <= StData;
        StData: begin
          hwdata_q <= m_hwdata;
          if (s_hready) begin
            txn_cnt <= txn_cnt + 32'd1;
            if (capture) state <= (load_cnt != '0) ? StWait : StIssue;
            else         state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_tb_ahb_stall_inj.sv
// Directed and random checks of the AHB stall injector against a small zero-wait memory
// model that answers address 0 with a two-cycle ERROR.
module tb_scr1_tb_ahb_stall_inj;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  stall_mode = 2'd0;
  logic [3:0]  stall_val = 4'd0;
  logic [1:0]  m_htrans = 2'b00;
  logic [31:0] m_haddr = 32'h0;
  logic        m_hwrite = 1'b0;
  logic [2:0]  m_hsize = 3'd2;
  logic [31:0] m_hwdata = 32'h0;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hready, s_hresp;
  logic [2:0]  s_hsize;
  logic [31:0] txn_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_tb_ahb_stall_inj #(.STALL_W(4), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .stall_mode(stall_mode), .stall_val(stall_val),
    .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hrdata(m_hrdata), .m_hresp(m_hresp),
    .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(s_hrdata), .s_hresp(s_hresp),
    .txn_cnt(txn_cnt), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h200) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Memory model: 4 KiB, word indexed by addr[11:2], reloaded on reset.
  logic [31:0] mem [0:1023];
  logic        ph_valid, ph_write, ph_err2;
  logic [31:0] ph_addr, rd_q;

  assign s_hready = !(ph_valid && ph_addr == 32'h0 && !ph_err2);
  assign s_hresp  = ph_valid && ph_addr == 32'h0;
  assign s_hrdata = rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_valid <= 1'b0;
      ph_write <= 1'b0;
      ph_err2  <= 1'b0;
      ph_addr  <= '0;
      rd_q     <= '0;
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(32'(i) << 2);
    end else begin
      if (ph_valid && ph_write && s_hready) mem[ph_addr[11:2]] <= s_hwdata;
      if (!s_hready) begin
        ph_err2 <= 1'b1;
      end else begin
        ph_err2  <= 1'b0;
        ph_valid <= s_htrans[1];
        ph_addr  <= s_haddr;
        ph_write <= s_hwrite;
        rd_q     <= mem[s_haddr[11:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Single transfer; lat = posedges from address cycle to the completing cycle.
  task automatic xfer(input logic [1:0] mode, input logic [3:0] val, input logic [31:0] addr,
                      input logic write, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic resp, output int lat,
                      output int iss, output logic [31:0] saddr, output logic swrite);
    @(negedge clk);
    stall_mode = mode;
    stall_val  = val;
    m_htrans   = 2'b10;
    m_haddr    = addr;
    m_hwrite   = write;
    lat = 0;
    iss = 0;
    saddr = '0;
    swrite = 1'b0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        m_htrans   = 2'b00;
        stall_mode = 2'd0;
        stall_val  = 4'd0;
        m_hwdata   = wdata;
      end
      @(negedge clk);
      if (s_htrans == 2'b10 && iss == 0) begin
        iss = lat;
        saddr = s_haddr;
        swrite = s_hwrite;
      end
    end while (!m_hready && lat < 100);
    rdata = m_hrdata;
    resp  = m_hresp;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  val;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] rdata, saddr, t0, s0, addr, sum;
    logic        resp, swrite;
    int          lat, iss, stall;
    bit          seen0, seen15, range_ok;

    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, saddr, t0, s0, addr, sum;
    logic        resp, swrite;
    int          lat, iss, stall;
    bit          seen0, seen15;

    vecs[0] = '{2'd0, 4'd0,  32'h200,  1'b0, 32'h0,         32'h0000_0013,     2};
    vecs[1] = '{2'd1, 4'd3,  32'h1000, 1'b1, 32'hDEAD_BEEF, 32'h0,             5};
    vecs[2] = '{2'd1, 4'd3,  32'h1000, 1'b0, 32'h0,         32'hDEAD_BEEF,     5};
    vecs[3] = '{2'd3, 4'd7,  32'h204,  1'b0, 32'h0,         init_word(32'h204), 2};
    vecs[4] = '{2'd1, 4'd15, 32'h300,  1'b0, 32'h0,         init_word(32'h300), 17};
    vecs[5] = '{2'd1, 4'd0,  32'h304,  1'b0, 32'h0,         init_word(32'h304), 2};
    vecs[6] = '{2'd0, 4'd9,  32'h308,  1'b0, 32'h0,         init_word(32'h308), 2};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_hready", 32'(m_hready), 32'd1);
    chk("rst_m_hresp", 32'(m_hresp), 32'd0);
    chk("rst_m_hrdata", m_hrdata, 32'h0);
    chk("rst_s_htrans", 32'(s_htrans), 32'd0);
    chk("rst_s_haddr", s_haddr, 32'h0);
    chk("rst_s_hwdata", s_hwdata, 32'h0);
    chk("rst_txn_cnt", txn_cnt, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single transfers; mode/val are cleared right after capture.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      t0 = txn_cnt;
      s0 = stall_cnt;
      xfer(vecs[i].mode, vecs[i].val, vecs[i].addr, vecs[i].write, vecs[i].wdata,
           rdata, resp, lat, iss, saddr, swrite);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_issue_cycle", i), 32'(iss), 32'(vecs[i].lat - 1));
      chk($sformatf("vec%0d_s_haddr", i), saddr, vecs[i].addr);
      chk($sformatf("vec%0d_s_hwrite", i), 32'(swrite), 32'(vecs[i].write));
      chk($sformatf("vec%0d_hresp", i), 32'(resp), 32'd0);
      if (!vecs[i].write) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].rdata);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_txn_delta", i), txn_cnt - t0, 32'd1);
      chk($sformatf("vec%0d_stall_delta", i), stall_cnt - s0, 32'(vecs[i].lat - 2));
      if (i == 0) begin
        chk("mode0_txn_cnt", txn_cnt, 32'd1);
        chk("mode0_stall_cnt", stall_cnt, 32'd0);
      end
    end

    // Reset asserted in the middle of a 5-cycle WAIT.
    @(negedge clk);
    stall_mode = 2'd1;
    stall_val  = 4'd5;
    m_htrans   = 2'b10;
    m_haddr    = 32'h400;
    m_hwrite   = 1'b0;
    @(posedge clk);
    #1;
    m_htrans = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk("prerst_m_hready", 32'(m_hready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_hready", 32'(m_hready), 32'd1);
    chk("midrst_s_htrans", 32'(s_htrans), 32'd0);
    chk("midrst_txn_cnt", txn_cnt, 32'd0);
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("postrst_idle_hready", 32'(m_hready), 32'd1);
      chk("postrst_idle_htrans", 32'(s_htrans), 32'd0);
    end

    // Back-to-back reads, mode 1, stall 2.
    @(negedge clk);
    stall_mode = 2'd1;
    stall_val  = 4'd2;
    m_htrans   = 2'b10;
    m_haddr    = 32'h200;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end while (!m_hready && lat < 100);
      chk($sformatf("b2b%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("b2b%0d_rdata", i), m_hrdata, init_word(32'h200 + 32'(4 * i)));
      if (i < 3) begin
        m_htrans = 2'b11;
        m_haddr  = 32'h204 + 32'(4 * i);
      end else begin
        m_htrans = 2'b00;
      end
    end
    @(posedge clk);
    #1;
    chk("b2b_txn_cnt", txn_cnt, 32'd4);
    chk("b2b_stall_cnt", stall_cnt, 32'd8);

    // Two-cycle ERROR response from address 0.
    @(negedge clk);
    t0 = txn_cnt;
    stall_mode = 2'd0;
    m_htrans   = 2'b10;
    m_haddr    = 32'h0;
    @(posedge clk);
    #1;
    m_htrans = 2'b00;
    @(negedge clk);
    chk("err_issue_hready", 32'(m_hready), 32'd0);
    chk("err_issue_hresp", 32'(m_hresp), 32'd0);
    @(negedge clk);
    chk("err_c1_hready", 32'(m_hready), 32'd0);
    chk("err_c1_hresp", 32'(m_hresp), 32'd1);
    @(negedge clk);
    chk("err_c2_hready", 32'(m_hready), 32'd1);
    chk("err_c2_hresp", 32'(m_hresp), 32'd1);
    @(negedge clk);
    chk("err_after_hresp", 32'(m_hresp), 32'd0);
    chk("err_txn_delta", txn_cnt - t0, 32'd1);

    // Random stalls with random addresses (address 0 is the error location, so excluded).
    s0 = stall_cnt;
    sum = '0;
    seen0 = 1'b0;
    seen15 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      addr = 32'($urandom_range(1, 1023)) << 2;
      xfer(2'd2, 4'hF, addr, 1'b0, 32'h0, rdata, resp, lat, iss, saddr, swrite);
      stall = lat - 2;
      chk("rand_rdata", rdata, init_word(addr));
      chk("rand_stall_in_range", 32'(stall >= 0 && stall <= 15), 32'd1);
      if (stall == 0) seen0 = 1'b1;
      if (stall == 15) seen15 = 1'b1;
      sum = sum + 32'(stall);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("rand_seen_stall0", 32'(seen0), 32'd1);
    chk("rand_seen_stall15", 32'(seen15), 32'd1);
    chk("rand_stall_sum", stall_cnt - s0, sum);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
